vscale_dmem_responder: RTL and testbench

- Shared data-memory HASTI (AHB-lite) responder sitting behind the multicore dmem arbiter; consumes the arbiter's dmem_* master port.
- Address bus is {core_idx, addr}. Two-phase pipelined protocol: address phase, then data phase one cycle later.
- Supports byte/halfword/word accesses, optional wait states, and the two-cycle AHB ERROR response.
- With PARTITIONED=1 the core index selects a private bank, giving per-core private memories.

---
 rtl/vscale_dmem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_vscale_dmem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_responder.sv
// Shared data-memory HASTI (AHB-lite) responder behind the multicore dmem arbiter.
// Two-phase pipelined slave: the address phase is registered, the data phase
// completes one cycle later (or after WAIT_CYCLES wait states). Illegal sizes,
// misaligned and out-of-range accesses get the two-cycle ERROR response.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   haddr         {core_idx, byte address}
//   hwrite        1 = write
//   hsize         0 byte, 1 half, 2 word
//   hburst        ignored (single beats only)
//   hmastlock     ignored
//   hprot         ignored
//   htrans        IDLE/BUSY/NONSEQ/SEQ
//   hwdata        write data, valid in the data phase
//   hrdata        read data, full word, valid in a read's DATA cycle (else 0)
//   hready        data phase completes / address accepted
//   hresp         OKAY/ERROR
//   dphase_core   core index owning the current data phase
module vscale_dmem_responder #(
  parameter int unsigned NWORDS         = 4096,
  parameter int unsigned PARTITIONED    = 0,
  parameter int unsigned WAIT_CYCLES    = 0,
  parameter int unsigned CORE_IDX_WIDTH = 1,
  localparam int unsigned HASTI_ADDR_WIDTH  = 32,
  localparam int unsigned HASTI_BUS_WIDTH   = 32,
  localparam int unsigned HASTI_SIZE_WIDTH  = 3,
  localparam int unsigned HASTI_BURST_WIDTH = 3,
  localparam int unsigned HASTI_PROT_WIDTH  = 4,
  localparam int unsigned HASTI_TRANS_WIDTH = 2,
  localparam int unsigned HASTI_RESP_WIDTH  = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [CORE_IDX_WIDTH+HASTI_ADDR_WIDTH-1:0] haddr,
  input  logic                                       hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]                hsize,
  input  logic [HASTI_BURST_WIDTH-1:0]               hburst,
  input  logic                                       hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]                hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0]               htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]                 hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]                 hrdata,
  output logic                                       hready,
  output logic [HASTI_RESP_WIDTH-1:0]                hresp,
  output logic [CORE_IDX_WIDTH-1:0]                  dphase_core
);

  localparam int unsigned IDX_W     = $clog2(NWORDS);
  localparam int unsigned MEM_IDX_W = (PARTITIONED != 0) ? IDX_W + CORE_IDX_WIDTH : IDX_W;
  localparam int unsigned DEPTH     = 1 << MEM_IDX_W;
  localparam int unsigned NBYTES    = HASTI_BUS_WIDTH / 8;

  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_SEQ    = 2'd3;
  localparam logic [HASTI_RESP_WIDTH-1:0]  RESP_OKAY    = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0]  RESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  // Registered state and data-phase context
  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        hready_q, hready_d;
  logic [HASTI_RESP_WIDTH-1:0] hresp_q, hresp_d;
  logic [CORE_IDX_WIDTH-1:0]   dp_core_q, dp_core_d;
  logic                        dp_write_q, dp_write_d;
  logic [1:0]                  dp_size_q, dp_size_d;
  logic [1:0]                  dp_lane_q, dp_lane_d;
  logic [MEM_IDX_W-1:0]        dp_idx_q, dp_idx_d;

  logic [HASTI_BUS_WIDTH-1:0]  mem [DEPTH];

  // Address-phase decode
  logic [CORE_IDX_WIDTH-1:0]   core_in;
  logic [HASTI_ADDR_WIDTH-1:0] addr_in;
  logic [IDX_W-1:0]            local_idx;
  logic [MEM_IDX_W-1:0]        index_in;
  logic                        accept;
  logic                        bad_xfer;
  logic [NBYTES-1:0]           be;
  logic                        unused_inputs;

  assign core_in   = haddr[HASTI_ADDR_WIDTH +: CORE_IDX_WIDTH];
  assign addr_in   = haddr[HASTI_ADDR_WIDTH-1:0];
  assign local_idx = addr_in[IDX_W+1:2];

  // Partitioned mode prepends the core index to give each core its own bank
  generate
    if (PARTITIONED != 0) begin : g_part
      assign index_in = {core_in, local_idx};
    end else begin : g_shared
      assign index_in = local_idx;
    end
  endgenerate

  assign accept = hready_q && ((htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ));

  // Range check uses the full word index, so high address bits never alias
  always_comb begin
    bad_xfer = 1'b0;
    if (addr_in[HASTI_ADDR_WIDTH-1:2] >= (HASTI_ADDR_WIDTH-2)'(NWORDS)) bad_xfer = 1'b1;
    if (hsize > 3'd2) bad_xfer = 1'b1;
    if ((hsize == 3'd1) && addr_in[0]) bad_xfer = 1'b1;
    if ((hsize == 3'd2) && (addr_in[1:0] != 2'b00)) bad_xfer = 1'b1;
  end

  // Next-state and data-phase context
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_core_d  = dp_core_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    dp_lane_d  = dp_lane_q;
    dp_idx_d   = dp_idx_q;
    case (state_q)
      S_WAIT: begin
        if ((5'(cnt_q) + 5'd1) >= 5'(WAIT_CYCLES)) begin
          state_d = S_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all drive hready=1 and may take a new address
        state_d = S_IDLE;
        if (accept) begin
          dp_core_d  = core_in;
          dp_write_d = hwrite;
          dp_size_d  = hsize[1:0];
          dp_lane_d  = addr_in[1:0];
          dp_idx_d   = index_in;
          cnt_d      = 4'd0;
          if (bad_xfer)             state_d = S_ERR1;
          else if (WAIT_CYCLES > 0) state_d = S_WAIT;
          else                      state_d = S_DATA;
        end
      end
    endcase
  end

  // Handshake outputs follow the next state so they are available from flops
  always_comb begin
    hready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_ERR2);
    hresp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      hready_q   <= 1'b1;
      hresp_q    <= RESP_OKAY;
      dp_core_q  <= '0;
      dp_write_q <= 1'b0;
      dp_size_q  <= 2'd0;
      dp_lane_q  <= 2'd0;
      dp_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      dp_core_q  <= dp_core_d;
      dp_write_q <= dp_write_d;
      dp_size_q  <= dp_size_d;
      dp_lane_q  <= dp_lane_d;
      dp_idx_q   <= dp_idx_d;
    end
  end

  // Byte-lane enables from the registered size and low address bits
  always_comb begin
    be = '0;
    case (dp_size_q)
      2'd0:    be = 4'b0001 << dp_lane_q;
      2'd1:    be = dp_lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Write commits on the edge that ends DATA; a reset on that edge drops it
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_DATA) && dp_write_q) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (be[i]) mem[dp_idx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Asynchronous read so a write committed on the previous edge is visible
  assign hrdata = ((state_q == S_DATA) && !dp_write_q) ? mem[dp_idx_q] : '0;

  assign hready      = hready_q;
  assign hresp       = hresp_q;
  assign dphase_core = dp_core_q;

  assign unused_inputs = ^{hburst, hmastlock, hprot};

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed bench for vscale_dmem_responder: a shared no-wait instance, a
// partitioned no-wait instance (same stimulus) and a shared 2-wait instance.
module tb_vscale_dmem_responder;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans, htrans_a, htrans_w;
  logic [31:0] hwdata;
  logic        tgt_w;

  logic [31:0] hrdata_0, hrdata_p, hrdata_w;
  logic        hready_0, hready_p, hready_w;
  logic        hresp_0, hresp_p, hresp_w;
  logic        dcore_0, dcore_p, dcore_w;
  logic        cur_ready;
  logic [31:0] cur_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Only the targeted group of instances sees real transfers
  assign htrans_a  = tgt_w ? T_IDLE : htrans;
  assign htrans_w  = tgt_w ? htrans : T_IDLE;
  assign cur_ready = tgt_w ? hready_w : hready_0;
  assign cur_rdata = tgt_w ? hrdata_w : hrdata_0;

  vscale_dmem_responder #(.NWORDS(1024), .PARTITIONED(0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans_a),
    .hwdata(hwdata), .hrdata(hrdata_0), .hready(hready_0), .hresp(hresp_0),
    .dphase_core(dcore_0));

  vscale_dmem_responder #(.NWORDS(1024), .PARTITIONED(1), .WAIT_CYCLES(0)) dutp (
    .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans_a),
    .hwdata(hwdata), .hrdata(hrdata_p), .hready(hready_p), .hresp(hresp_p),
    .dphase_core(dcore_p));

  vscale_dmem_responder #(.NWORDS(1024), .PARTITIONED(0), .WAIT_CYCLES(2)) dutw (
    .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans_w),
    .hwdata(hwdata), .hrdata(hrdata_w), .hready(hready_w), .hresp(hresp_w),
    .dphase_core(dcore_w));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input logic tw, input logic core, input logic [31:0] a,
                         input logic wr, input logic [2:0] sz);
    tgt_w  = tw;
    haddr  = {core, a};
    hwrite = wr;
    hsize  = sz;
    htrans = T_NONSEQ;
  endtask

  task automatic go_idle();
    htrans = T_IDLE;
  endtask

  // Single transfer from an idle bus; waits (bounded) for the data phase
  task automatic xfer(input logic tw, input logic core, input logic [31:0] a,
                      input logic wr, input logic [31:0] data,
                      output logic [31:0] rd, output logic ok);
    int n;
    addr_ph(tw, core, a, wr, 3'd2);
    tick();
    go_idle();
    hwdata = data;
    n = 0;
    while (!cur_ready && n < 32) begin
      tick();
      n++;
    end
    ok = cur_ready;
    rd = cur_rdata;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (hready_0 !== 1'b1) begin n_fail++; $display("FAIL rst_hready_0: got %b want 1", hready_0); end
    n_checks++; if (hresp_0 !== 1'b0) begin n_fail++; $display("FAIL rst_hresp_0: got %b want 0", hresp_0); end
    n_checks++; if (hrdata_0 !== 32'h0) begin n_fail++; $display("FAIL rst_hrdata_0: got %h want 0", hrdata_0); end
    n_checks++; if (dcore_0 !== 1'b0) begin n_fail++; $display("FAIL rst_dcore_0: got %b want 0", dcore_0); end
    n_checks++; if (hready_w !== 1'b1) begin n_fail++; $display("FAIL rst_hready_w: got %b want 1", hready_w); end
    n_checks++; if (hresp_w !== 1'b0) begin n_fail++; $display("FAIL rst_hresp_w: got %b want 0", hresp_w); end
    n_checks++; if (hready_p !== 1'b1) begin n_fail++; $display("FAIL rst_hready_p: got %b want 1", hready_p); end
    n_checks++; if (dcore_p !== 1'b0) begin n_fail++; $display("FAIL rst_dcore_p: got %b want 0", dcore_p); end
  endtask

  task automatic test_word_rw();
    addr_ph(1'b0, 1'b0, 32'h100, 1'b1, 3'd2);
    tick();
    hwdata = 32'hDEADBEEF;
    addr_ph(1'b0, 1'b0, 32'h100, 1'b0, 3'd2);
    n_checks++; if (hready_0 !== 1'b1) begin n_fail++; $display("FAIL wr_dphase_hready: got %b want 1", hready_0); end
    n_checks++; if (hrdata_0 !== 32'h0) begin n_fail++; $display("FAIL wr_dphase_hrdata: got %h want 0", hrdata_0); end
    tick();
    go_idle();
    n_checks++; if (hready_0 !== 1'b1) begin n_fail++; $display("FAIL rd_dphase_hready: got %b want 1", hready_0); end
    n_checks++; if (hrdata_0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_readback: got %h want deadbeef", hrdata_0); end
    n_checks++; if (hresp_0 !== 1'b0) begin n_fail++; $display("FAIL word_hresp: got %b want 0", hresp_0); end
    tick();
    n_checks++; if (hrdata_0 !== 32'h0) begin n_fail++; $display("FAIL idle_hrdata: got %h want 0", hrdata_0); end
  endtask

  task automatic test_byte_lanes();
    addr_ph(1'b0, 1'b0, 32'h200, 1'b1, 3'd2);
    tick();
    hwdata = 32'h11223344;
    addr_ph(1'b0, 1'b0, 32'h202, 1'b1, 3'd0);
    tick();
    hwdata = 32'h00AA0000;
    addr_ph(1'b0, 1'b0, 32'h200, 1'b0, 3'd2);
    tick();
    go_idle();
    n_checks++; if (hrdata_0 !== 32'h11AA3344) begin n_fail++; $display("FAIL byte_lane: got %h want 11aa3344", hrdata_0); end
    tick();
    addr_ph(1'b0, 1'b0, 32'h206, 1'b1, 3'd1);
    tick();
    hwdata = 32'hBEEF0000;
    addr_ph(1'b0, 1'b0, 32'h204, 1'b0, 3'd2);
    tick();
    go_idle();
    n_checks++; if (hrdata_0[31:16] !== 16'hBEEF) begin n_fail++; $display("FAIL half_lane: got %h want beef", hrdata_0[31:16]); end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        ok;
    xfer(1'b0, 1'b0, 32'h300, 1'b1, 32'h12345678, rd, ok);
    xfer(1'b0, 1'b0, 32'h000, 1'b1, 32'h0BADF00D, rd, ok);
    addr_ph(1'b0, 1'b0, 32'h301, 1'b1, 3'd1);
    tick();
    go_idle();
    hwdata = 32'hFFFFFFFF;
    n_checks++; if ({hready_0, hresp_0} !== 2'b01) begin n_fail++; $display("FAIL half_err1: got rdy/resp %b want 01", {hready_0, hresp_0}); end
    tick();
    n_checks++; if ({hready_0, hresp_0} !== 2'b11) begin n_fail++; $display("FAIL half_err2: got rdy/resp %b want 11", {hready_0, hresp_0}); end
    addr_ph(1'b0, 1'b0, 32'h1000, 1'b1, 3'd2);
    tick();
    go_idle();
    n_checks++; if ({hready_0, hresp_0} !== 2'b01) begin n_fail++; $display("FAIL range_err1: got rdy/resp %b want 01", {hready_0, hresp_0}); end
    tick();
    n_checks++; if ({hready_0, hresp_0} !== 2'b11) begin n_fail++; $display("FAIL range_err2: got rdy/resp %b want 11", {hready_0, hresp_0}); end
    addr_ph(1'b0, 1'b0, 32'h300, 1'b0, 3'd2);
    tick();
    go_idle();
    n_checks++; if (hresp_0 !== 1'b0) begin n_fail++; $display("FAIL post_err_hresp: got %b want 0", hresp_0); end
    n_checks++; if (hrdata_0 !== 32'h12345678) begin n_fail++; $display("FAIL err_no_write_300: got %h want 12345678", hrdata_0); end
    tick();
    xfer(1'b0, 1'b0, 32'h000, 1'b0, 32'h0, rd, ok);
    n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL err_no_write_0: got %h want 0badf00d", rd); end
    addr_ph(1'b0, 1'b0, 32'h304, 1'b0, 3'd3);
    tick();
    go_idle();
    n_checks++; if ({hready_0, hresp_0} !== 2'b01) begin n_fail++; $display("FAIL size_err1: got rdy/resp %b want 01", {hready_0, hresp_0}); end
    tick();
    tick();
    n_checks++; if ({hready_0, hresp_0} !== 2'b10) begin n_fail++; $display("FAIL err_to_idle: got rdy/resp %b want 10", {hready_0, hresp_0}); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        ok;
    addr_ph(1'b1, 1'b0, 32'h100, 1'b1, 3'd2);
    tick();
    go_idle();
    hwdata = 32'hCAFEF00D;
    tick();
    tick();
    n_checks++; if (hready_w !== 1'b1) begin n_fail++; $display("FAIL wait_wr_data: got %b want 1", hready_w); end
    addr_ph(1'b1, 1'b0, 32'h100, 1'b0, 3'd2);
    tick();
    addr_ph(1'b1, 1'b0, 32'h104, 1'b1, 3'd2);
    n_checks++; if (hready_w !== 1'b0) begin n_fail++; $display("FAIL wait_cyc1: got %b want 0", hready_w); end
    n_checks++; if (hrdata_w !== 32'h0) begin n_fail++; $display("FAIL wait_cyc1_hrdata: got %h want 0", hrdata_w); end
    tick();
    n_checks++; if (hready_w !== 1'b0) begin n_fail++; $display("FAIL wait_cyc2: got %b want 0", hready_w); end
    tick();
    n_checks++; if (hready_w !== 1'b1) begin n_fail++; $display("FAIL wait_done: got %b want 1", hready_w); end
    n_checks++; if (hrdata_w !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait_rdata: got %h want cafef00d", hrdata_w); end
    tick();
    go_idle();
    hwdata = 32'h00000077;
    n_checks++; if (hready_w !== 1'b0) begin n_fail++; $display("FAIL held_addr_accept: got %b want 0", hready_w); end
    tick();
    tick();
    n_checks++; if (hready_w !== 1'b1) begin n_fail++; $display("FAIL held_addr_data: got %b want 1", hready_w); end
    tick();
    xfer(1'b1, 1'b0, 32'h104, 1'b0, 32'h0, rd, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wait_rd_timeout: got ok %b want 1", ok); end
    n_checks++; if (rd !== 32'h00000077) begin n_fail++; $display("FAIL held_addr_value: got %h want 00000077", rd); end
    tgt_w = 1'b0;
  endtask

  task automatic test_partition();
    addr_ph(1'b0, 1'b0, 32'h40, 1'b1, 3'd2);
    tick();
    hwdata = 32'd1;
    addr_ph(1'b0, 1'b1, 32'h40, 1'b1, 3'd2);
    n_checks++; if (dcore_p !== 1'b0) begin n_fail++; $display("FAIL part_dcore_w0: got %b want 0", dcore_p); end
    tick();
    hwdata = 32'd2;
    addr_ph(1'b0, 1'b0, 32'h40, 1'b0, 3'd2);
    n_checks++; if (dcore_p !== 1'b1) begin n_fail++; $display("FAIL part_dcore_w1: got %b want 1", dcore_p); end
    tick();
    addr_ph(1'b0, 1'b1, 32'h40, 1'b0, 3'd2);
    n_checks++; if (hrdata_p !== 32'd1) begin n_fail++; $display("FAIL part_core0: got %h want 1", hrdata_p); end
    n_checks++; if (hrdata_0 !== 32'd2) begin n_fail++; $display("FAIL shared_core0: got %h want 2", hrdata_0); end
    n_checks++; if (dcore_p !== 1'b0) begin n_fail++; $display("FAIL part_dcore_r0: got %b want 0", dcore_p); end
    tick();
    go_idle();
    n_checks++; if (hrdata_p !== 32'd2) begin n_fail++; $display("FAIL part_core1: got %h want 2", hrdata_p); end
    n_checks++; if (hrdata_0 !== 32'd2) begin n_fail++; $display("FAIL shared_core1: got %h want 2", hrdata_0); end
    n_checks++; if (dcore_p !== 1'b1) begin n_fail++; $display("FAIL part_dcore_r1: got %b want 1", dcore_p); end
    tick();
    n_checks++; if (dcore_p !== 1'b1) begin n_fail++; $display("FAIL dcore_hold_idle: got %b want 1", dcore_p); end
  endtask

  task automatic test_reset_midxfer();
    logic [31:0] rd;
    logic        ok;
    xfer(1'b1, 1'b0, 32'h500, 1'b1, 32'hA5A5A5A5, rd, ok);
    addr_ph(1'b1, 1'b0, 32'h500, 1'b1, 3'd2);
    tick();
    go_idle();
    hwdata = 32'h5;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (hready_w !== 1'b1) begin n_fail++; $display("FAIL rstw_hready: got %b want 1", hready_w); end
    n_checks++; if (hresp_w !== 1'b0) begin n_fail++; $display("FAIL rstw_hresp: got %b want 0", hresp_w); end
    n_checks++; if (hrdata_w !== 32'h0) begin n_fail++; $display("FAIL rstw_hrdata: got %h want 0", hrdata_w); end
    tick();
    tick();
    xfer(1'b1, 1'b0, 32'h500, 1'b0, 32'h0, rd, ok);
    n_checks++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rstw_mem_kept: got %h want a5a5a5a5", rd); end
    xfer(1'b0, 1'b0, 32'h500, 1'b1, 32'hA5A5A5A5, rd, ok);
    addr_ph(1'b0, 1'b0, 32'h500, 1'b1, 3'd2);
    tick();
    go_idle();
    hwdata = 32'h5;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (hready_0 !== 1'b1) begin n_fail++; $display("FAIL rst0_hready: got %b want 1", hready_0); end
    xfer(1'b0, 1'b0, 32'h500, 1'b0, 32'h0, rd, ok);
    n_checks++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rst0_no_commit: got %h want a5a5a5a5", rd); end
  endtask

  initial begin
    reset     = 1'b1;
    tgt_w     = 1'b0;
    haddr     = '0;
    hwrite    = 1'b0;
    hsize     = 3'd2;
    hburst    = 3'd0;
    hmastlock = 1'b0;
    hprot     = 4'b0011;
    htrans    = T_IDLE;
    hwdata    = '0;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_errors();
    test_wait_states();
    test_partition();
    test_reset_midxfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
